// File: rtl/bus_types_pkg.sv
// Shared bus structures between the fetch/dispatch sequencer, memory and register file.
package bus_types_pkg;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] offset;
      logic [31:0] data;
      logic [1:0]  mode;
   } mem_in_bus_t;

   typedef struct packed {
      logic [2:0]  sel;
      logic [31:0] data;
      logic        mode;
   } reg_in_bus_t;

endpackage

// File: rtl/fetch_dispatch_unit_pkg.sv
// Opcode encoding, instruction field positions and sequencer states for fetch_dispatch_unit.
package fetch_dispatch_unit_pkg;

   typedef enum logic [3:0] {
      OP_CMOV     = 4'd0,
      OP_AINDEX   = 4'd1,
      OP_AAMEND   = 4'd2,
      OP_ADD      = 4'd3,
      OP_MUL      = 4'd4,
      OP_DIV      = 4'd5,
      OP_NAND     = 4'd6,
      OP_HALT     = 4'd7,
      OP_ALLOC    = 4'd8,
      OP_ABANDON  = 4'd9,
      OP_OUTPUT   = 4'd10,
      OP_INPUT    = 4'd11,
      OP_LOADPROG = 4'd12,
      OP_ORTHO    = 4'd13
   } op_t;

   localparam int OP_LSB      = 28;
   localparam int A_LSB       = 6;
   localparam int B_LSB       = 3;
   localparam int C_LSB       = 0;
   localparam int ORTHO_A_LSB = 25;
   localparam int ORTHO_VAL_W = 25;

   typedef enum logic [3:0] {
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_DECODE,
      S_EXECUTE,
      S_LP_SEL,
      S_LP_LATCH,
      S_ORTHO,
      S_HALTED,
      S_FAULT
   } fetch_state_t;

   function automatic logic [3:0] field_op(input logic [31:0] w);
      return w[OP_LSB +: 4];
   endfunction

endpackage

// File: rtl/fetch_dispatch_unit_exec_watchdog.sv
// Counts cycles spent in EXECUTE; expired flags the cycle in which the count reaches WATCHDOG_CYCLES.
module fetch_dispatch_unit_exec_watchdog #(
   parameter int unsigned WATCHDOG_CYCLES = 0
) (
   input  logic clk,
   input  logic r_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q + 1 includes the current cycle, so expiry lands on the Nth EXECUTE cycle.
   assign expired = (WATCHDOG_CYCLES != 0) && enable && ((count_q + 32'd1) == WATCHDOG_CYCLES);

endmodule

// File: rtl/fetch_dispatch_unit.sv
// Fetches and decodes instruction words, sequences the per-opcode execution FSMs,
// and executes orthography and the PC half of load-program locally.
module fetch_dispatch_unit
   import bus_types_pkg::*;
   import fetch_dispatch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET        = 32'h0,
   parameter int unsigned WATCHDOG_CYCLES = 0
) (
   input  logic        clk,
   input  logic        r_n,
   input  logic [31:0] mem_data_out_bus,
   input  logic [31:0] reg_out_bus,
   input  logic        exec_finished,
   output mem_in_bus_t mem_in,
   output reg_in_bus_t reg_in,
   output logic        fetch_owns_bus,
   output logic [3:0]  exec_op,
   output logic [2:0]  regA,
   output logic [2:0]  regB,
   output logic [2:0]  regC,
   output logic        exec_r,
   output logic [31:0] pc,
   output logic [31:0] retired,
   output logic        halted,
   output logic        fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  retired_q, retired_d;
   logic         halted_q, halted_d;
   logic         fault_q, fault_d;
   logic [3:0]   op_q, op_d;
   logic [2:0]   rega_q, rega_d, regb_q, regb_d, regc_q, regc_d;
   logic         wd_clear, wd_enable, wd_expired;
   logic [3:0]   dec_op;

   assign dec_op = field_op(instr_q);

   fetch_dispatch_unit_exec_watchdog #(
      .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .r_n     (r_n),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      halted_d  = halted_q;
      fault_d   = fault_q;
      op_d      = op_q;
      rega_d    = rega_q;
      regb_d    = regb_q;
      regc_d    = regc_q;
      mem_in    = '0;
      reg_in    = '0;
      wd_clear  = 1'b1;
      wd_enable = 1'b0;
      case (state_q)
         S_FETCH_REQ: begin
            mem_in.offset = pc_q;
            state_d       = S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            mem_in.offset = pc_q;
            instr_d       = mem_data_out_bus;
            state_d       = S_DECODE;
         end
         S_DECODE: begin
            op_d   = dec_op;
            rega_d = instr_q[A_LSB +: 3];
            regb_d = instr_q[B_LSB +: 3];
            regc_d = instr_q[C_LSB +: 3];
            pc_d   = pc_q + 32'd1;
            case (dec_op)
               OP_HALT: begin
                  halted_d  = 1'b1;
                  retired_d = retired_q + 32'd1;
                  state_d   = S_HALTED;
               end
               OP_ORTHO:     state_d = S_ORTHO;
               4'd14, 4'd15: begin
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end
               default:      state_d = S_EXECUTE;
            endcase
         end
         S_EXECUTE: begin
            wd_clear  = 1'b0;
            wd_enable = 1'b1;
            // finished takes priority over a same-cycle watchdog expiry
            if (exec_finished) begin
               if (op_q == OP_LOADPROG) begin
                  state_d = S_LP_SEL;
               end else begin
                  retired_d = retired_q + 32'd1;
                  state_d   = S_FETCH_REQ;
               end
            end else if (wd_expired) begin
               fault_d = 1'b1;
               state_d = S_FAULT;
            end
         end
         S_LP_SEL: begin
            reg_in.sel = regc_q;
            state_d    = S_LP_LATCH;
         end
         S_LP_LATCH: begin
            pc_d      = reg_out_bus;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH_REQ;
         end
         S_ORTHO: begin
            reg_in.sel  = instr_q[ORTHO_A_LSB +: 3];
            reg_in.data = {{(32 - ORTHO_VAL_W){1'b0}}, instr_q[ORTHO_VAL_W-1:0]};
            reg_in.mode = 1'b1;
            retired_d   = retired_q + 32'd1;
            state_d     = S_FETCH_REQ;
         end
         S_HALTED: state_d = S_HALTED;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FETCH_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state_q   <= S_FETCH_REQ;
         pc_q      <= PC_RESET;
         instr_q   <= '0;
         retired_q <= '0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
         op_q      <= '0;
         rega_q    <= '0;
         regb_q    <= '0;
         regc_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
         op_q      <= op_d;
         rega_q    <= rega_d;
         regb_q    <= regb_d;
         regc_q    <= regc_d;
      end
   end

   // Execution FSMs only run, and only own the buses, while EXECUTE is active.
   assign exec_r         = (state_q != S_EXECUTE);
   assign fetch_owns_bus = (state_q != S_EXECUTE);
   assign exec_op        = op_q;
   assign regA           = rega_q;
   assign regB           = regb_q;
   assign regC           = regc_q;
   assign pc             = pc_q;
   assign retired        = retired_q;
   assign halted         = halted_q;
   assign fault          = fault_q;

endmodule

// File: tb/tb_fetch_dispatch_unit.sv
// Directed scoreboard bench for fetch_dispatch_unit with simple memory and register-file models.
module tb_fetch_dispatch_unit;
   import bus_types_pkg::*;

   localparam logic [31:0] PC_RST = 32'h0;
   localparam int unsigned WD     = 8;
   localparam logic [31:0] W_HALT = 32'h7000_0000;

   // clock / reset
   logic clk = 1'b0;
   logic r_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem_data_out_bus;
   logic [31:0] reg_out_bus;
   logic        exec_finished;
   mem_in_bus_t mem_in;
   reg_in_bus_t reg_in;
   logic        fetch_owns_bus;
   logic [3:0]  exec_op;
   logic [2:0]  regA, regB, regC;
   logic        exec_r;
   logic [31:0] pc, retired;
   logic        halted, fault;

   fetch_dispatch_unit #(
      .PC_RESET        (PC_RST),
      .WATCHDOG_CYCLES (WD)
   ) dut (
      .clk              (clk),
      .r_n              (r_n),
      .mem_data_out_bus (mem_data_out_bus),
      .reg_out_bus      (reg_out_bus),
      .exec_finished    (exec_finished),
      .mem_in           (mem_in),
      .reg_in           (reg_in),
      .fetch_owns_bus   (fetch_owns_bus),
      .exec_op          (exec_op),
      .regA             (regA),
      .regB             (regB),
      .regC             (regC),
      .exec_r           (exec_r),
      .pc               (pc),
      .retired          (retired),
      .halted           (halted),
      .fault            (fault)
   );

   // memory and register file: read data one cycle after the address/sel
   logic [31:0] mem [0:127];
   logic [31:0] rf  [0:7];
   always @(posedge clk) begin
      mem_data_out_bus <= mem[mem_in.offset[6:0]];
      reg_out_bus      <= rf[reg_in.sel];
   end

   // scoreboard
   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check_pop(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         check(tag, obs, e);
      end
   endtask

   // drivers
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_reset();
      r_n           = 1'b0;
      exec_finished = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = W_HALT;
      for (int i = 0; i < 8; i++) rf[i] = 32'h0;
      @(negedge clk);
   endtask

   task automatic release_reset();
      r_n = 1'b1;
   endtask

   initial begin : time_limit
      #200000;
      $display("FAIL time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      int bad;
      exec_finished = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = W_HALT;
      for (int i = 0; i < 8; i++) rf[i] = 32'h0;
      tick(2);

      // reset values
      check("rst_pc", pc, PC_RST);
      check("rst_retired", retired, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_exec_r", {31'd0, exec_r}, 32'd1);
      check("rst_reg_mode", {31'd0, reg_in.mode}, 32'd0);
      check("rst_mem_mode", {30'd0, mem_in.mode}, 32'd0);
      check("rst_owns", {31'd0, fetch_owns_bus}, 32'd1);

      // orthography: A'=1, value=5
      hold_reset();
      mem[0] = 32'hD200_0005;
      push_exp(PC_RST); push_exp(32'd1); push_exp(32'd5); push_exp(32'd1);
      push_exp(32'd1); push_exp(32'd1);
      release_reset();
      check_pop("ortho_fetch0", mem_in.offset);
      tick(2);
      check("ortho_pre_mode", {31'd0, reg_in.mode}, 32'd0);
      tick(1);
      check_pop("ortho_sel", {29'd0, reg_in.sel});
      check_pop("ortho_data", reg_in.data);
      check_pop("ortho_mode", {31'd0, reg_in.mode});
      tick(1);
      check("ortho_post_mode", {31'd0, reg_in.mode}, 32'd0);
      check_pop("ortho_next_fetch", mem_in.offset);
      check_pop("ortho_retired", retired);

      // ADD A=3 B=2 C=1, finished after 4 execute cycles
      hold_reset();
      mem[0] = 32'h3000_00D1;
      push_exp(32'd3); push_exp(32'd3); push_exp(32'd2); push_exp(32'd1);
      push_exp(32'd1); push_exp(32'd1);
      release_reset();
      tick(2);
      check("add_decode_exec_r", {31'd0, exec_r}, 32'd1);
      tick(1);
      check("add_exec_r", {31'd0, exec_r}, 32'd0);
      check("add_owns", {31'd0, fetch_owns_bus}, 32'd0);
      check_pop("add_op", {28'd0, exec_op});
      check_pop("add_regA", {29'd0, regA});
      check_pop("add_regB", {29'd0, regB});
      check_pop("add_regC", {29'd0, regC});
      tick(3);
      exec_finished = 1'b1;
      check("add_pre_retired", retired, 32'd0);
      tick(1);
      exec_finished = 1'b0;
      check_pop("add_next_fetch", mem_in.offset);
      check_pop("add_retired", retired);
      check("add_after_exec_r", {31'd0, exec_r}, 32'd1);

      // asynchronous reset while in EXECUTE
      hold_reset();
      mem[0] = 32'h3000_0000;
      release_reset();
      tick(3);
      check("midrst_pc_before", pc, 32'd1);
      #2 r_n = 1'b0;
      #1;
      check("midrst_exec_r", {31'd0, exec_r}, 32'd1);
      check("midrst_pc", pc, PC_RST);
      check("midrst_owns", {31'd0, fetch_owns_bus}, 32'd1);
      check("midrst_reg_mode", {31'd0, reg_in.mode}, 32'd0);
      @(negedge clk);
      r_n = 1'b1;
      push_exp(PC_RST);
      check_pop("midrst_first_fetch", mem_in.offset);

      // load-program: pc taken from register C, then halt at the new pc
      hold_reset();
      mem[0] = 32'hC000_0002;
      rf[2]  = 32'h40;
      push_exp(32'd2); push_exp(32'h40); push_exp(32'h40); push_exp(32'd1);
      push_exp(32'd2); push_exp(32'h41);
      release_reset();
      tick(3);
      exec_finished = 1'b1;
      tick(1);
      exec_finished = 1'b0;
      check_pop("lp_sel", {29'd0, reg_in.sel});
      check("lp_sel_mode", {31'd0, reg_in.mode}, 32'd0);
      check("lp_sel_retired", retired, 32'd0);
      check("lp_sel_exec_r", {31'd0, exec_r}, 32'd1);
      tick(2);
      check_pop("lp_fetch", mem_in.offset);
      check_pop("lp_pc", pc);
      check_pop("lp_retired", retired);
      tick(3);
      check("halt_set", {31'd0, halted}, 32'd1);
      check("halt_no_fault", {31'd0, fault}, 32'd0);
      check_pop("halt_retired", retired);
      check_pop("halt_pc", pc);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (halted !== 1'b1 || mem_in.offset !== 32'd0 || retired !== 32'd2) bad++;
      end
      check("halt_hold_bad_cycles", 32'(bad), 32'd0);

      // illegal opcode 14
      hold_reset();
      mem[0] = 32'hE000_0000;
      release_reset();
      tick(3);
      check("ill_fault", {31'd0, fault}, 32'd1);
      check("ill_halted", {31'd0, halted}, 32'd0);
      check("ill_pc", pc, 32'd1);
      check("ill_retired", retired, 32'd0);
      tick(5);
      check("ill_pc_frozen", pc, 32'd1);
      check("ill_fault_sticky", {31'd0, fault}, 32'd1);

      // watchdog expiry after exactly WD execute cycles
      hold_reset();
      mem[0] = 32'h3000_0000;
      release_reset();
      tick(3 + WD - 1);
      check("wd_last_exec_no_fault", {31'd0, fault}, 32'd0);
      check("wd_last_exec_r", {31'd0, exec_r}, 32'd0);
      tick(1);
      check("wd_fault", {31'd0, fault}, 32'd1);
      check("wd_retired", retired, 32'd0);
      check("wd_exec_r", {31'd0, exec_r}, 32'd1);

      // finished on the expiry cycle wins
      hold_reset();
      mem[0] = 32'h3000_0000;
      push_exp(32'd1); push_exp(32'd1);
      release_reset();
      tick(3 + WD - 1);
      exec_finished = 1'b1;
      tick(1);
      exec_finished = 1'b0;
      check("wd_edge_no_fault", {31'd0, fault}, 32'd0);
      check_pop("wd_edge_retired", retired);
      check_pop("wd_edge_fetch", mem_in.offset);

      if (exp_q.size() != 0) begin
         n_checks++;
         $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_dispatch_unit.md
Name: fetch_dispatch_unit

Overview:
- Upstream sequencer of the control unit. Fetches each instruction word from array 0 at the PC and decodes its opcode and register fields.
- Sequences the per-opcode execution FSMs (cmov, array index, array amend, ALU, alloc, etc.). It holds them in reset, releases the selected one, and waits for its finished.
- Executes orthography (op 13) and the PC update of load-program (op 12) itself. Halts on op 7; faults on ops 14/15 or execution timeout.

Parameters:
- PC_RESET, 32'h0, PC value loaded on reset.
- WATCHDOG_CYCLES, 0, maximum cycles in EXECUTE before FAULT; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- r_n  input  1  reset, asynchronous, active-low.
- mem_data_out_bus  input  32  memory read data; valid the cycle after the request cycle.
- reg_out_bus  input  32  register-file read data; valid the cycle after reg_in.sel is presented.
- exec_finished  input  1  finished of the selected execution FSM (muxed by exec_op at top level).
- mem_in  output  mem_in_bus_t  fetch request bus.
- reg_in  output  reg_in_bus_t  register-file access for op 12/13.
- fetch_owns_bus  output  1  high when this block drives mem_in/reg_in; low in EXECUTE, when the exec FSM owns them.
- exec_op  output  4  latched opcode.
- regA, regB, regC  output  3 each  latched instruction fields.
- exec_r  output  1  active-high synchronous reset to the execution FSMs.
- pc  output  32  current program counter.
- retired  output  32  retired-instruction count.
- halted  output  1  sticky; set by op 7.
- fault  output  1  sticky; set by illegal opcode or watchdog expiry.

Behaviour:
- Reset (r_n low, asynchronous, any state): state=FETCH_REQ, pc=PC_RESET, instr=0, retired=0, halted=0, fault=0, watchdog=0.
  - Outputs during reset: exec_r=1, reg_in.mode=0, mem_in.mode=2'b00.
  - First request issues on the first rising clk edge after deassertion.
- Fields: op=instr[31:28], A=instr[8:6], B=instr[5:3], C=instr[2:0]. Orthography: A'=instr[27:25], value=instr[24:0] zero-extended.
- exec_r = (state != EXECUTE). Stale FIN/finished from the previous instruction therefore can never be seen.
- mem_in, outside FETCH_REQ/FETCH_WAIT: address=0, offset=0, data=0, mode=00.
- reg_in default: sel=0, data=0, mode=0.
- States:
  - FETCH_REQ: mem_in.address=0, offset=pc, mode=00; fetch_owns_bus=1. -> FETCH_WAIT.
  - FETCH_WAIT: request held. At the edge, instr<=mem_data_out_bus. -> DECODE.
  - DECODE: latch exec_op/regA/B/C; pc<=pc+1 (32-bit wrap, FFFFFFFF->0). Transition by op:
    - op 7: -> HALTED.
    - op 13: -> ORTHO.
    - op 14/15: -> FAULT.
    - otherwise: -> EXECUTE.
  - EXECUTE: exec_r=0, fetch_owns_bus=0, watchdog increments each cycle.
    - On exec_finished=1: op 12 -> LP_SEL; else retired++, -> FETCH_REQ. Watchdog cleared on exit.
    - If WATCHDOG_CYCLES!=0 and watchdog==WATCHDOG_CYCLES with exec_finished=0: -> FAULT.
    - exec_finished and expiry in the same cycle: finished wins.
  - LP_SEL: reg_in.sel=regC, mode=0. -> LP_LATCH.
  - LP_LATCH: pc<=reg_out_bus (overrides DECODE increment); retired++. -> FETCH_REQ.
  - ORTHO: reg_in.sel=A', data=value, mode=1 for exactly this one cycle; retired++. -> FETCH_REQ.
  - HALTED: halted=1; terminal until reset; retired++ on entry. Op 7 is counted as retired.
  - FAULT: fault=1; terminal until reset; pc and retired frozen.
- fetch_owns_bus=1 in FETCH_REQ, FETCH_WAIT, DECODE, LP_SEL, LP_LATCH, ORTHO, HALTED, FAULT.
- Latency:
  - Non-dispatched ops: fetch-to-fetch is 4 cycles (ORTHO).
  - Dispatched ops: 3 cycles + exec FSM cycles + 1 retire cycle.
  - Op 12 adds 2 cycles after finished.

Decomposition:
- New package OpTypes: opcode enum op_t (CMOV=0 … ORTHO=13), field bit-position constants, state enum fetch_state_t.
- mem_in_bus_t and reg_in_bus_t stay in BusTypes.
- One sub-module: exec_watchdog (counter with clear/enable/expired, parameterised by WATCHDOG_CYCLES).

Test Plan:
- Reset mid-EXECUTE (r_n low for 1 cycle) -> outputs at reset values immediately, without waiting for clk; first request after release has mem_in.offset=PC_RESET.
- Word 32'hD2000005 (ORTHO, A'=1, value=5) at offset 0 -> exactly 1 cycle with reg_in.sel=1, data=5, mode=1; next request offset=1; retired=1.
- Word 32'h300000D1 (ADD, A=3, B=2, C=1) -> exec_op=3, regA/B/C=3/2/1; exec_r=0 from the cycle after DECODE; exec_finished after 4 cycles -> FETCH_REQ with offset=1.
- Op 12 with reg_out_bus returning 32'h40 during LP_LATCH -> next fetch offset=32'h40, not pc+1.
- Op 7 -> halted=1 and stays 1 for 100 cycles; no further mem requests. Op 14 -> fault=1, halted=0.
- WATCHDOG_CYCLES=8, exec_finished held 0 -> fault=1 after exactly 8 EXECUTE cycles; repeat with finished on the 8th cycle -> no fault.
